// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter
package mem_arb_pkg;
  localparam int WORD = 32;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ireq,
  input  logic [WORD-1:0] iadr,
  output logic            iack,
  output logic [WORD-1:0] irdata,
  input  logic            dreq,
  input  logic            dwe,
  input  logic [WORD-1:0] dadr,
  input  logic [WORD-1:0] dwdata,
  output logic            dack,
  output logic [WORD-1:0] drdata,
  output logic            err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [WORD-1:0] mem_adr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ready
);
  state_t          state, state_n;
  port_t           last, owner, pick;
  logic            we, err_q, timeout, grant, done;
  logic [WORD-1:0] adr, wdata, rdata;
  logic [7:0]      cnt;
  always_comb begin
    pick    = (ireq && dreq) ? ((last == PORT_D) ? PORT_I : PORT_D) : (dreq ? PORT_D : PORT_I);
    timeout = cnt == 8'(TIMEOUT - 1);
    grant   = state == IDLE && (ireq || dreq);
    done    = state == BUSY && (mem_ready || timeout);
    state_n = state == IDLE ? (grant ? BUSY : IDLE) :
              state == BUSY ? (done ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= PORT_D;
      owner <= PORT_I;
      we    <= 1'b0;
      adr   <= '0;
      wdata <= '0;
      rdata <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner <= pick;
        we    <= pick == PORT_D && dwe;
        adr   <= (pick == PORT_D) ? dadr : iadr;
        wdata <= (pick == PORT_D) ? dwdata : '0;
        cnt   <= '0;
      end
      if (state == BUSY) cnt <= cnt + 8'd1;
      // a timed-out access returns zero data with err set
      if (done) begin
        rdata <= (mem_ready && !we) ? mem_rdata : '0;
        err_q <= !mem_ready;
      end
      if (state == RESP) last <= owner;
    end
  end
  assign mem_en    = state == BUSY;
  assign mem_we    = mem_en && we;
  assign mem_adr   = adr;
  assign mem_wdata = wdata;
  assign iack      = state == RESP && owner == PORT_I;
  assign dack      = state == RESP && owner == PORT_D;
  assign err       = state == RESP && err_q;
  assign irdata    = rdata;
  assign drdata    = rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mem_ready = 1'b0;
  logic [31:0] iadr = '0, dadr = '0, dwdata = '0, mem_rdata = '0;
  logic        iack, dack, err, mem_en, mem_we;
  logic [31:0] irdata, drdata, mem_adr, mem_wdata;
  int          n_chk = 0, n_fail = 0;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .iack(iack), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .dack(dack), .drdata(drdata),
    .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_iack", 32'(iack), 0);
    chk("rst_dack", 32'(dack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_irdata", irdata, 0);
    chk("rst_drdata", drdata, 0);
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    chk("idle_ready_ignored", 32'(mem_en), 0);
    // lone fetch, zero wait
    ireq = 1'b1; iadr = 32'h40; mem_rdata = 32'h20020005;
    step();
    chk("fetch_mem_en", 32'(mem_en), 1);
    chk("fetch_mem_adr", mem_adr, 32'h40);
    chk("fetch_mem_we", 32'(mem_we), 0);
    chk("fetch_no_ack_yet", 32'(iack), 0);
    step();
    chk("fetch_iack", 32'(iack), 1);
    chk("fetch_dack", 32'(dack), 0);
    chk("fetch_irdata", irdata, 32'h20020005);
    chk("fetch_err", 32'(err), 0);
    ireq = 1'b0; mem_ready = 1'b0;
    step();
    chk("fetch_iack_pulse", 32'(iack), 0);
    // store with 3 wait cycles
    dreq = 1'b1; dwe = 1'b1; dadr = 32'h54; dwdata = 32'd7;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("store_mem_en", 32'(mem_en), 1);
      chk("store_mem_we", 32'(mem_we), 1);
      chk("store_mem_adr", mem_adr, 32'h54);
      chk("store_mem_wdata", mem_wdata, 32'd7);
      chk("store_no_ack", 32'(dack), 0);
    end
    mem_ready = 1'b1; mem_rdata = 32'hdeadbeef;
    step();
    chk("store_dack", 32'(dack), 1);
    chk("store_iack", 32'(iack), 0);
    chk("store_drdata", drdata, 0);
    chk("store_err", 32'(err), 0);
    dreq = 1'b0; dwe = 1'b0;
    step();
    chk("store_dack_pulse", 32'(dack), 0);
    // contention: I, D, I, D
    ireq = 1'b1; dreq = 1'b1; iadr = 32'h100; dadr = 32'h200; mem_rdata = 32'h11;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("cont_iack", 32'(iack), 32'(k == 2 || k == 8));
      chk("cont_dack", 32'(dack), 32'(k == 5 || k == 11));
      if (k % 3 == 1) chk("cont_mem_adr", mem_adr, (k % 6 == 1) ? 32'h100 : 32'h200);
    end
    ireq = 1'b0; dreq = 1'b0; mem_ready = 1'b0;
    step();
    // timeout on a data read
    dreq = 1'b1; dadr = 32'h70f00ff0; mem_rdata = 32'h12345678;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("to_mem_en", 32'(mem_en), 1);
      chk("to_no_ack", 32'(dack), 0);
    end
    step();
    chk("to_dack", 32'(dack), 1);
    chk("to_err", 32'(err), 1);
    chk("to_drdata", drdata, 0);
    chk("to_mem_en_off", 32'(mem_en), 0);
    dreq = 1'b0;
    step();
    chk("to_idle_err", 32'(err), 0);
    chk("to_idle_mem_en", 32'(mem_en), 0);
    // fetch so that the last winner is I before the reset test
    ireq = 1'b1; iadr = 32'h80; mem_ready = 1'b1; mem_rdata = 32'h5;
    step();
    step();
    chk("pre_iack", 32'(iack), 1);
    ireq = 1'b0; mem_ready = 1'b0;
    step();
    // reset during the 2nd BUSY cycle
    dreq = 1'b1; dadr = 32'h500;
    step();
    step();
    chk("rmid_busy", 32'(mem_en), 1);
    reset = 1'b1; dreq = 1'b0;
    step();
    chk("rmid_mem_en", 32'(mem_en), 0);
    chk("rmid_mem_adr", mem_adr, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rmid_no_iack", 32'(iack), 0);
      chk("rmid_no_dack", 32'(dack), 0);
    end
    ireq = 1'b1; dreq = 1'b1; iadr = 32'h300; dadr = 32'h400; mem_ready = 1'b1; mem_rdata = 32'h77;
    step();
    chk("post_rst_tie_adr", mem_adr, 32'h300);
    step();
    chk("post_rst_iack", 32'(iack), 1);
    chk("post_rst_dack", 32'(dack), 0);
    chk("post_rst_irdata", irdata, 32'h77);
    ireq = 1'b0; dreq = 1'b0; mem_ready = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared main-memory port between the MIPS core's instruction-fetch port and data port. Sits between the core and the memory model inside `top`. Each access is latched at grant and held stable on the memory side until the memory responds or a timeout expires. The result is returned to the requester with a one-cycle acknowledge.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of BUSY cycles to wait for `mem_ready` before aborting. Legal range 2..255.

Ports:
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ireq`  in  1  instruction-fetch request; read only.
- `iadr`  in  32  instruction address.
- `iack`  out  1  one-cycle pulse; `irdata` and `err` are valid while it is high.
- `irdata`  out  32  fetched word.
- `dreq`  in  1  data request.
- `dwe`  in  1  data write enable; qualified by `dreq`.
- `dadr`  in  32  data address.
- `dwdata`  in  32  data write value.
- `dack`  out  1  one-cycle pulse.
- `drdata`  out  32  load result; 0 for writes.
- `err`  out  1  valid with `iack`/`dack`; 1 means the access timed out.
- `mem_en`  out  1  memory access in progress.
- `mem_we`  out  1  write strobe; qualified by `mem_en`.
- `mem_adr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current access this cycle.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that did not win the previous grant (round robin). The `last` pointer resets to D, so the first tie goes to I.
  - On grant: latch the owner, `we` (always 0 for I), address and write data; go to BUSY; clear the wait counter.
- **BUSY**
  - Outputs: `mem_en`=1; `mem_we`, `mem_adr`, `mem_wdata` are driven from the latches and stay constant through BUSY.
  - `mem_ready`=1: capture `mem_rdata` (0 if it was a write); set `err`=0; go to RESP.
  - Otherwise: increment the counter. When the counter reaches `TIMEOUT`-1 with no ready, capture data 0, set `err`=1, and go to RESP.
- **RESP**
  - Assert the owner's ack for exactly one cycle; the other ack stays 0. `last` is updated to the owner.
  - Always go to IDLE. No grant happens in RESP.
- **Requester rules**
  - Hold `req`, address, `we` and write data stable from assertion until ack.
  - Drop `req` in the cycle after ack, or keep it high to issue a new access, which is arbitrated on the next IDLE cycle.
  - Changing inputs while waiting is illegal.
- **Reset**
  - Synchronous; it overrides everything, including mid-BUSY. The in-flight access is abandoned with no ack.
  - Reset values: state IDLE, `last`=D, counter 0.
  - `iack`, `dack`, `err`, `mem_en`, `mem_we` are 0. `mem_adr`, `mem_wdata`, `irdata`, `drdata` are 0.
- **Ignored inputs:** `mem_ready` is ignored outside BUSY. `dwe` is ignored when `dreq`=0.

## Timing
- Zero-wait memory (`mem_ready` high in the first BUSY cycle):
  - request seen in IDLE at cycle n;
  - BUSY at n+1;
  - ack at n+2.
- With k wait cycles, ack arrives at n+2+k.
- Back-to-back throughput is one access per 3 cycles.
- Timeout: BUSY lasts exactly `TIMEOUT` cycles, and ack with `err`=1 comes in the following cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `*req` or `mem_ready` to any output.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/RESP);
  - the owner encoding (PORT_I=0, PORT_D=1);
  - the width constant `WORD=32`.
- No sub-module is needed. The round-robin pointer, wait counter (8 bits) and request latch all live in `mem_arbiter`.

## Test plan
- **Lone fetch:** `ireq`, `iadr`=0x40, memory returns 0x20020005 with zero wait → `mem_adr`=0x40, `mem_we`=0 in cycle n+1; `iack`=1, `irdata`=0x20020005, `err`=0 at n+2.
- **Store with wait:** `dreq`, `dwe`=1, `dadr`=0x54, `dwdata`=7, 3 wait cycles → `mem_we`=1, `mem_adr`=0x54, `mem_wdata`=7 held 4 cycles; `dack` at n+5, `drdata`=0.
- **Contention:** both requests held continuously, zero-wait memory → grants alternate I, D, I, D; acks at n+2, n+5, n+8, n+11, with none missing and none duplicated.
- **Timeout:** `dreq` read of 0x70f00ff0, `mem_ready` never asserted, `TIMEOUT`=16 → `mem_en` high for 16 cycles; `dack`=1, `err`=1, `drdata`=0 at n+17; then IDLE.
- **Reset mid-access:** `reset` pulsed in the 2nd BUSY cycle → next cycle `mem_en`=0, no ack ever issued. A following tie grants I first.
